// File: rtl/router_pkt_tx.sv
// Packet source for the router input port: buffers payload bytes, then sends
// header {len,addr}, len payload bytes and an XOR parity byte, stalling on busy.
module router_pkt_tx #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned PTR_W = 6
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ld_en,
    input  logic [7:0]       ld_data,
    output logic [PTR_W:0]   buf_count,
    input  logic             start,
    input  logic [1:0]       addr,
    input  logic [5:0]       len,
    input  logic             busy,
    output logic             pkt_valid,
    output logic [7:0]       data_out,
    output logic             tx_active,
    output logic             done,
    output logic             reject
);

    typedef enum logic [1:0] {StIdle, StHeader, StPayload, StParity} state_e;

    state_e             state_q, state_d;
    logic [5:0]         len_q, len_d;
    logic [1:0]         addr_q, addr_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [7:0]         parity_q, parity_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [7:0]         mem [DEPTH];

    logic               pkt_valid_d, tx_active_d, done_d, reject_d;
    logic [7:0]         data_out_d;
    logic               start_ok, push, pop;

    assign start_ok  = start && (len != 6'd0) && (addr != 2'b11) &&
                       (count_q >= (PTR_W+1)'(len));
    assign pop       = (state_q == StPayload) && !busy;
    // A load into a full buffer is dropped even if a pop happens the same cycle.
    assign push      = ld_en && (count_q != (PTR_W+1)'(DEPTH));
    assign rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    assign wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    assign count_d   = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    assign buf_count = count_q;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= ld_data;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            len_q     <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            parity_q  <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            pkt_valid <= 1'b0;
            data_out  <= '0;
            tx_active <= 1'b0;
            done      <= 1'b0;
            reject    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            parity_q  <= parity_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            pkt_valid <= pkt_valid_d;
            data_out  <= data_out_d;
            tx_active <= tx_active_d;
            done      <= done_d;
            reject    <= reject_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        parity_d = parity_q;
        case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = StHeader;
                    len_d   = len;
                    addr_d  = addr;
                end
            end
            StHeader: begin
                if (!busy) begin
                    state_d  = StPayload;
                    cnt_d    = '0;
                    parity_d = {len_q, addr_q};
                end
            end
            StPayload: begin
                if (!busy) begin
                    parity_d = parity_q ^ mem[rd_ptr_q];
                    cnt_d    = cnt_q + 6'd1;
                    if (cnt_q == len_q - 6'd1) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (!busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        pkt_valid_d = (state_d == StHeader) || (state_d == StPayload);
        tx_active_d = (state_d != StIdle);
        done_d      = (state_q == StParity) && !busy;
        reject_d    = (state_q == StIdle) && start && !start_ok;
        data_out_d  = '0;
        case (state_d)
            StHeader:  data_out_d = {len_d, addr_d};
            StPayload: data_out_d = mem[rd_ptr_d];
            StParity:  data_out_d = parity_d;
            default:   data_out_d = '0;
        endcase
    end

endmodule
